// File: rtl/gate_selftest_seq.sv
// rtl/gate_selftest_seq.sv - exhaustive 2-input gate stimulus/check sequencer
module gate_selftest_seq #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  ab_q, ab_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [2:0]  err_q, err_d;
    logic [3:0]  mask_q, mask_d;

    logic        mismatch;
    logic [2:0]  err_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE: state_d = (idx_q == 2'd3) ? S_IDLE : S_SETTLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Compare happens only in SAMPLE; Y is don't-care elsewhere.
    assign mismatch = (Y != EXPECTED[idx_q]);
    assign err_next = err_q + {2'b00, mismatch};

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        ab_d   = ab_q;
        busy_d = busy_q;
        done_d = 1'b0;
        pass_d = pass_q;
        err_d  = err_q;
        mask_d = mask_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d  = 2'd0;
                    cnt_d  = 4'd0;
                    ab_d   = 2'b00;
                    busy_d = 1'b1;
                    pass_d = 1'b0;
                    err_d  = 3'd0;
                    mask_d = 4'd0;
                end
            end
            S_SETTLE: cnt_d = cnt_q + 4'd1;
            S_SAMPLE: begin
                err_d = err_next;
                if (mismatch) mask_d[idx_q] = 1'b1;
                if (idx_q != 2'd3) begin
                    idx_d = idx_q + 2'd1;
                    ab_d  = idx_q + 2'd1;
                    cnt_d = 4'd0;
                end else begin
                    ab_d   = 2'b00;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_next == 3'd0);
                end
            end
            default: ;
        endcase
    end

    assign A         = ab_q[1];
    assign B         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule
